// File: rtl/seq_generator_if.sv
// Handshake and serial-output bundle of the sync+payload frame transmitter.
// The master side requests frames and the slave side is the transmitter itself.
interface seq_generator_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              busy;
    logic              x;
    logic              x_valid;
    logic              done;

    modport master (
        output start, data_in,
        input  ready, busy, x, x_valid, done
    );

    modport slave (
        input  start, data_in,
        output ready, busy, x, x_valid, done
    );
endinterface

// File: rtl/seq_generator.sv
// Serial frame transmitter: sync word then latched payload, MSB first, one bit
// per clock, followed by an idle gap whose first cycle carries a done pulse.
module seq_generator #(
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1010,
    parameter int                DATA_W   = 8,
    parameter int                GAP      = 2
) (
    input logic            clk,
    input logic            rst_n,
    seq_generator_if.slave bus
);
    localparam int TOT_W   = SYNC_W + DATA_W;
    localparam int BIT_MAX = ((SYNC_W > DATA_W) ? SYNC_W : DATA_W) - 1;
    localparam int BIT_CW  = (BIT_MAX > 0) ? $clog2(BIT_MAX + 1) : 1;
    localparam int GAP_CW  = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_GAP
    } state_t;

    state_t             state;
    logic [TOT_W-1:0]   shreg;
    logic [BIT_CW-1:0]  bit_cnt;
    logic [GAP_CW-1:0]  gap_cnt;
    logic               x_valid_q;
    logic               done_q;
    logic               ready_q;

    // The serial bit is the shift register MSB; the frame shifts zeros in behind
    // it, so the line idles low once the last payload bit has left.
    assign bus.x       = shreg[TOT_W-1];
    assign bus.x_valid = x_valid_q;
    assign bus.done    = done_q;
    assign bus.ready   = ready_q;
    assign bus.busy    = ~ready_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        shreg     <= {SYNC_PAT, bus.data_in};
                        bit_cnt   <= BIT_CW'(SYNC_W - 1);
                        x_valid_q <= 1'b1;
                        ready_q   <= 1'b0;
                        state     <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    shreg <= shreg << 1;
                    if (bit_cnt == '0) begin
                        bit_cnt <= BIT_CW'(DATA_W - 1);
                        state   <= S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    shreg <= shreg << 1;
                    if (bit_cnt == '0) begin
                        x_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                        gap_cnt   <= GAP_CW'(GAP - 1);
                        state     <= S_GAP;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_generator.sv
// Scoreboard bench for seq_generator: stimulus queues the expected per-cycle
// outputs of each frame, a negedge monitor compares every cycle against them.
module tb_seq_generator;
    localparam int DATA_W = 8;

    typedef struct {
        int   cyc;
        logic x;
        logic xv;
        logic done;
        logic ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   acc;
    exp_t sb[$];

    logic [2:0] hist = '0;
    int         pos = 0;
    int         det_cnt = 0;
    bit         det_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_generator_if #(.DATA_W(DATA_W)) bus ();

    seq_generator #(.DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Expected waveform of one frame whose first bit appears in cycle a:
    // 12 valid bits, then the done cycle, then the second (silent) gap cycle.
    task automatic push_frame(input int a, input logic [11:0] bits);
        for (int i = 0; i < 12; i++)
            sb.push_back('{cyc: a + i, x: bits[11-i], xv: 1'b1, done: 1'b0, ready: 1'b0});
        sb.push_back('{cyc: a + 12, x: 1'b0, xv: 1'b0, done: 1'b1, ready: 1'b0});
        sb.push_back('{cyc: a + 13, x: 1'b0, xv: 1'b0, done: 1'b0, ready: 1'b0});
    endtask

    function automatic int pack(logic x, logic xv, logic dn, logic rdy, logic bsy);
        return int'({x, xv, dn, rdy, bsy});
    endfunction

    // Monitor plus a behavioural 1010 detector fed from the serial line.
    always @(negedge clk) begin
        exp_t e;
        int   act;
        act = pack(bus.x, bus.x_valid, bus.done, bus.ready, bus.busy);
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("frame", act, pack(e.x, e.xv, e.done, e.ready, ~e.ready));
        end else begin
            check("idle", act, pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        if (bus.x_valid) begin
            if (det_en && {hist, bus.x} == 4'b1010) begin
                det_cnt <= det_cnt + 1;
                check("det_pos", pos, 3);
            end
            hist <= {hist[1:0], bus.x};
            pos  <= pos + 1;
        end else begin
            hist <= '0;
            pos  <= 0;
        end
    end

    initial begin
        bus.start   = 1'b0;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single A5 frame; data_in change and a second start mid-frame are ignored.
        bus.data_in = 8'hA5;
        bus.start   = 1'b1;
        acc = cyc + 1;
        push_frame(acc, 12'b1010_1010_0101);
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < acc + 2) @(negedge clk);
        bus.data_in = 8'hFF;
        while (cyc < acc + 4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < acc + 20) @(negedge clk);

        // Back-to-back with start held and a zero payload, detector in the loop.
        det_en      = 1'b1;
        bus.data_in = 8'h00;
        bus.start   = 1'b1;
        acc = cyc + 1;
        push_frame(acc, 12'b1010_0000_0000);
        push_frame(acc + 15, 12'b1010_0000_0000);
        while (cyc < acc + 15) @(negedge clk);
        bus.start = 1'b0;
        while (cyc < acc + 34) @(negedge clk);
        det_en = 1'b0;
        check("det_count", det_cnt, 2);

        // Start held through reset: nothing may begin until release.
        bus.start = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("rst_hold", pack(bus.x, bus.x_valid, bus.done, bus.ready, bus.busy),
                 pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        acc = cyc + 1;
        push_frame(acc, 12'b1010_0000_0000);
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < acc + 18) @(negedge clk);

        // Asynchronous reset in the middle of a frame while x is high.
        bus.data_in = 8'hFF;
        bus.start   = 1'b1;
        acc = cyc + 1;
        push_frame(acc, 12'b1010_1111_1111);
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < acc + 5) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1 check("rst_async", pack(bus.x, bus.x_valid, bus.done, bus.ready, bus.busy),
                 pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Fresh frame after the interrupted one must be complete and correct.
        bus.data_in = 8'h5A;
        bus.start   = 1'b1;
        acc = cyc + 1;
        push_frame(acc, 12'b1010_0101_1010);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
